// File: rtl/t04_screen_sequencer_if.sv
// Handshake bundle between the screen sequencer, the screen counter and the LCD byte driver.
interface t04_screen_sequencer_if;
  logic [22:0] ct;
  logic        update_req;
  logic [7:0]  update_cmd;
  logic [15:0] update_pix;
  logic        tx_ready;
  logic        enable_edge;
  logic        ack;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_dc;
  logic        busy;
  logic        err;

  modport master (
    input  ct, update_req, update_cmd, update_pix, tx_ready,
    output enable_edge, ack, tx_valid, tx_byte, tx_dc, busy, err
  );

  modport slave (
    output ct, update_req, update_cmd, update_pix, tx_ready,
    input  enable_edge, ack, tx_valid, tx_byte, tx_dc, busy, err
  );
endinterface

// File: rtl/t04_screen_sequencer.sv
// Runs one screen update: start pulse, settle on ct, stream cmd + 16-bit pixel, then hold ack
// long enough for the screen counter's synchroniser to observe it.
module t04_screen_sequencer #(
  parameter logic [22:0] WAIT_CT    = 23'd100,
  parameter logic [22:0] TIMEOUT_CT = 23'h7FFFFF,
  parameter int unsigned ACK_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  t04_screen_sequencer_if.master        bus
);

  localparam int unsigned      ACK_W    = $clog2(ACK_CYCLES);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT, SEND_CMD, SEND_HI, SEND_LO, ACK
  } state_t;

  state_t           state, state_next;
  logic [7:0]       cmd_q;
  logic [15:0]      pix_q;
  logic             err_q;
  logic [ACK_W-1:0] ack_cnt;
  logic             sending;
  logic             xfer;
  logic             timeout;

  assign sending = (state == SEND_CMD) || (state == SEND_HI) || (state == SEND_LO);
  assign xfer    = sending && bus.tx_ready;
  // A transfer on the deadline cycle takes priority over abandoning the byte.
  assign timeout = sending && !bus.tx_ready && (bus.ct >= TIMEOUT_CT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cmd_q   <= '0;
      pix_q   <= '0;
      err_q   <= 1'b0;
      ack_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.update_req) begin
        cmd_q <= bus.update_cmd;
        pix_q <= bus.update_pix;
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
      ack_cnt <= (state == ACK && state_next == ACK) ? ack_cnt + ACK_W'(1) : '0;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (bus.update_req) state_next = START;
      START:    state_next = WAIT;
      WAIT:     if (bus.ct >= WAIT_CT) state_next = SEND_CMD;
      SEND_CMD: begin
        if (xfer)         state_next = SEND_HI;
        else if (timeout) state_next = ACK;
      end
      SEND_HI: begin
        if (xfer)         state_next = SEND_LO;
        else if (timeout) state_next = ACK;
      end
      SEND_LO:  if (xfer || timeout) state_next = ACK;
      ACK:      if (ack_cnt == ACK_LAST) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.enable_edge = 1'b0;
    bus.ack         = 1'b0;
    bus.tx_valid    = 1'b0;
    bus.tx_byte     = '0;
    bus.tx_dc       = 1'b0;
    bus.busy        = (state != IDLE);
    bus.err         = err_q;
    unique case (state)
      START:    bus.enable_edge = 1'b1;
      SEND_CMD: begin
        bus.tx_valid = 1'b1;
        bus.tx_byte  = cmd_q;
      end
      SEND_HI: begin
        bus.tx_valid = 1'b1;
        bus.tx_byte  = pix_q[15:8];
        bus.tx_dc    = 1'b1;
      end
      SEND_LO: begin
        bus.tx_valid = 1'b1;
        bus.tx_byte  = pix_q[7:0];
        bus.tx_dc    = 1'b1;
      end
      ACK:      bus.ack = 1'b1;
      default:  ;
    endcase
  end

endmodule
